// File: rtl/mem_write_checker.sv
// mem_write_checker: data-memory write monitor with programmable pass entries.
// Per-entry data masking is built only when MWCHK_DATA_MASK_EN is defined.
module mem_write_checker #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int NUM_CHK = 4,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1000,
  parameter int DRAIN   = 10,
  localparam int IDX_W  = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic              cfg_en,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [DATA_W-1:0] cfg_mask,
  output logic [2:0]        state,
  output logic              done,
  output logic              pass,
  output logic [3:0]        hit_idx,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  write_cnt,
  output logic [ADDR_W-1:0] last_addr,
  output logic [DATA_W-1:0] last_data
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_DRAIN   = 3'd2,
    S_PASS    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  localparam int DRW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [DRW-1:0] DRAIN_LD = DRW'((DRAIN > 0) ? DRAIN - 1 : 0);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  state_t r_state;
  state_t w_next;

  logic [NUM_CHK-1:0] r_en;
  logic [ADDR_W-1:0]  r_addr [NUM_CHK];
  logic [DATA_W-1:0]  r_data [NUM_CHK];
`ifdef MWCHK_DATA_MASK_EN
  logic [DATA_W-1:0]  r_mask [NUM_CHK];
`else
  logic w_unused_mask;
  assign w_unused_mask = &{1'b0, cfg_mask};
`endif

  logic [DRW-1:0]    r_drain;
  logic [3:0]        r_hit_idx;
  logic [CNT_W-1:0]  r_cyc;
  logic [CNT_W-1:0]  r_wr;
  logic [ADDR_W-1:0] r_last_a;
  logic [DATA_W-1:0] r_last_d;

  logic [NUM_CHK-1:0] w_match;
  logic [3:0]         w_hit_idx;
  logic               w_hit;
  logic               w_wr;
  logic               w_active;
  logic               w_run_hit;
  logic               w_timeout;
  logic [CNT_W-1:0]   w_cyc_inc;
  logic [CNT_W-1:0]   w_wr_inc;

  assign w_wr      = |memwrite;
  assign w_active  = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_cyc_inc = (&r_cyc) ? r_cyc : r_cyc + 1'b1;
  assign w_wr_inc  = (&r_wr) ? r_wr : r_wr + 1'b1;
  assign w_timeout = (w_cyc_inc == TO_VAL);

  // Compare against stored entries, so a same-cycle cfg_we sees old contents
  always_comb begin
    w_match = '0;
    for (int i = 0; i < NUM_CHK; i++) begin
`ifdef MWCHK_DATA_MASK_EN
      w_match[i] = w_wr && r_en[i] && (r_addr[i] == dataadr) &&
                   ((writedata & r_mask[i]) == (r_data[i] & r_mask[i]));
`else
      w_match[i] = w_wr && r_en[i] && (r_addr[i] == dataadr) &&
                   (writedata == r_data[i]);
`endif
    end
  end

  always_comb begin
    w_hit_idx = '0;
    for (int i = NUM_CHK - 1; i >= 0; i--) begin
      if (w_match[i]) w_hit_idx = 4'(i);
    end
  end

  assign w_hit     = |w_match;
  assign w_run_hit = (r_state == S_RUN) && w_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (start) begin
      w_next = S_RUN;
    end else begin
      unique case (r_state)
        S_RUN: begin
          if (w_hit) w_next = (DRAIN == 0) ? S_PASS : S_DRAIN;
          else if (w_timeout) w_next = S_TIMEOUT;
        end
        S_DRAIN: if (r_drain == '0) w_next = S_PASS;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drain <= '0;
    end else if (start) begin
      r_drain <= '0;
    end else if (w_run_hit) begin
      r_drain <= DRAIN_LD;
    end else if (r_state == S_DRAIN && r_drain != '0) begin
      r_drain <= r_drain - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cyc     <= '0;
      r_wr      <= '0;
      r_last_a  <= '0;
      r_last_d  <= '0;
      r_hit_idx <= '0;
    end else if (start) begin
      r_cyc     <= '0;
      r_wr      <= '0;
      r_last_a  <= '0;
      r_last_d  <= '0;
      r_hit_idx <= '0;
    end else if (w_active) begin
      r_cyc <= w_cyc_inc;
      if (w_wr) begin
        r_wr     <= w_wr_inc;
        r_last_a <= dataadr;
        r_last_d <= writedata;
      end
      if (w_run_hit) r_hit_idx <= w_hit_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en <= '0;
      for (int i = 0; i < NUM_CHK; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
`ifdef MWCHK_DATA_MASK_EN
        r_mask[i] <= '0;
`endif
      end
    end else if (cfg_we && (32'(cfg_idx) < NUM_CHK)) begin
      r_en[cfg_idx]   <= cfg_en;
      r_addr[cfg_idx] <= cfg_addr;
      r_data[cfg_idx] <= cfg_data;
`ifdef MWCHK_DATA_MASK_EN
      r_mask[cfg_idx] <= cfg_mask;
`endif
    end
  end

  assign state     = r_state;
  assign done      = (r_state == S_PASS) || (r_state == S_TIMEOUT);
  assign pass      = (r_state == S_PASS);
  assign hit_idx   = r_hit_idx;
  assign cycle_cnt = r_cyc;
  assign write_cnt = r_wr;
  assign last_addr = r_last_a;
  assign last_data = r_last_d;

endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: randomized write traces scored against an outcome
// model derived from the entry table and the run/drain/timeout rules.
module tb_mem_write_checker;

  localparam int NC   = 4;
  localparam int TO   = 1000;
  localparam int DR   = 10;
  localparam int MAXC = 1100;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  memwrite;
  logic [63:0] dataadr;
  logic [63:0] writedata;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic        cfg_en;
  logic [63:0] cfg_addr;
  logic [63:0] cfg_data;
  logic [63:0] cfg_mask;
  logic [2:0]  state;
  logic        done;
  logic        pass;
  logic [3:0]  hit_idx;
  logic [31:0] cycle_cnt;
  logic [31:0] write_cnt;
  logic [63:0] last_addr;
  logic [63:0] last_data;

  mem_write_checker dut (
    .clk(clk), .reset(reset), .start(start),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_mask(cfg_mask),
    .state(state), .done(done), .pass(pass), .hit_idx(hit_idx),
    .cycle_cnt(cycle_cnt), .write_cnt(write_cnt),
    .last_addr(last_addr), .last_data(last_data)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // model of the entry table
  bit          m_en [NC];
  logic [63:0] m_a  [NC];
  logic [63:0] m_d  [NC];
  logic [63:0] m_m  [NC];

  // per-cycle stimulus, index = RUN cycle number (1-based)
  logic [1:0]  s_mw [MAXC+1];
  logic [63:0] s_a  [MAXC+1];
  logic [63:0] s_d  [MAXC+1];
  bit          s_cw [MAXC+1];
  logic [63:0] s_ca [MAXC+1];
  logic [63:0] s_cd [MAXC+1];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit dmatch(logic [63:0] w, logic [63:0] d, logic [63:0] m);
`ifdef MWCHK_DATA_MASK_EN
    return (w & m) == (d & m);
`else
    return (w == d) || (m != m);
`endif
  endfunction

  task automatic idle_inputs();
    start = 0; memwrite = 0; dataadr = 0; writedata = 0;
    cfg_we = 0; cfg_idx = 0; cfg_en = 0;
    cfg_addr = 0; cfg_data = 0; cfg_mask = 0;
  endtask

  task automatic cfg_write(int i, bit en, logic [63:0] a, logic [63:0] d,
                           logic [63:0] m);
    @(negedge clk);
    cfg_we = 1; cfg_idx = 2'(i); cfg_en = en;
    cfg_addr = a; cfg_data = d; cfg_mask = m;
    @(negedge clk);
    cfg_we = 0;
    m_en[i] = en; m_a[i] = a; m_d[i] = d; m_m[i] = m;
  endtask

  task automatic clear_all_entries();
    for (int i = 0; i < NC; i++) cfg_write(i, 0, 0, 0, 0);
  endtask

  task automatic clear_stim();
    for (int c = 0; c <= MAXC; c++) begin
      s_mw[c] = 0; s_a[c] = 0; s_d[c] = 0;
      s_cw[c] = 0; s_ca[c] = 0; s_cd[c] = 0;
    end
  endtask

  // random writes to addresses with bit 32 set: never match a small entry
  task automatic fill_random();
    for (int c = 1; c <= MAXC; c++) begin
      if ($urandom_range(0, 1) == 1) begin
        s_mw[c] = 2'($urandom_range(1, 3));
        s_a[c]  = {32'h1, $urandom};
        s_d[c]  = {$urandom, $urandom};
      end
    end
  endtask

  task automatic apply(int c);
    memwrite = s_mw[c]; dataadr = s_a[c]; writedata = s_d[c];
    cfg_we = s_cw[c]; cfg_idx = 0; cfg_en = 1;
    cfg_addr = s_ca[c]; cfg_data = s_cd[c]; cfg_mask = '1;
  endtask

  // Outcome of a whole run from the trace and entry table
  task automatic model(output int k, output int endc, output logic [2:0] est,
                       output logic [3:0] ehit, output int wc,
                       output logic [63:0] la, output logic [63:0] ld);
    bit          en [NC];
    logic [63:0] ea [NC];
    logic [63:0] ed [NC];
    logic [63:0] em [NC];
    for (int i = 0; i < NC; i++) begin
      en[i] = m_en[i]; ea[i] = m_a[i]; ed[i] = m_d[i]; em[i] = m_m[i];
    end
    k = 0; ehit = 0;
    for (int c = 1; c <= TO && k == 0; c++) begin
      if (s_mw[c] != 0) begin
        for (int i = NC - 1; i >= 0; i--) begin
          if (en[i] && ea[i] == s_a[c] && dmatch(s_d[c], ed[i], em[i])) begin
            k = c; ehit = 4'(i);
          end
        end
      end
      if (s_cw[c]) begin
        en[0] = 1; ea[0] = s_ca[c]; ed[0] = s_cd[c]; em[0] = '1;
      end
    end
    endc = (k != 0) ? k + DR : TO;
    est  = (k != 0) ? 3'd3 : 3'd4;
    wc = 0; la = 0; ld = 0;
    for (int c = 1; c <= endc; c++) begin
      if (s_mw[c] != 0) begin
        wc++; la = s_a[c]; ld = s_d[c];
      end
    end
  endtask

  task automatic run(string tag);
    int k, endc, wc, dc, fin;
    logic [2:0] est;
    logic [3:0] ehit;
    logic [63:0] la, ld;
    model(k, endc, est, ehit, wc, la, ld);
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    chk({tag, ".run"}, 64'(state), 64'd1);
    dc = 0; fin = 0;
    for (int c = 1; c <= MAXC; c++) begin
      apply(c);
      @(negedge clk);
      if (state == 3'd2 && dc == 0) dc = c;
      if (done) begin fin = c; break; end
    end
    idle_inputs();
    chk({tag, ".state"}, 64'(state), 64'(est));
    chk({tag, ".done"}, 64'(done), 64'd1);
    chk({tag, ".pass"}, 64'(pass), 64'(est == 3'd3));
    chk({tag, ".hit_idx"}, 64'(hit_idx), 64'(ehit));
    chk({tag, ".cycle_cnt"}, 64'(cycle_cnt), 64'(endc));
    chk({tag, ".write_cnt"}, 64'(write_cnt), 64'(wc));
    chk({tag, ".last_addr"}, last_addr, la);
    chk({tag, ".last_data"}, last_data, ld);
    chk({tag, ".drain_at"}, 64'(dc), 64'(k));
    chk({tag, ".end_cycle"}, 64'(fin), 64'(endc));
  endtask

  task automatic chk_zero(string tag);
    chk({tag, ".state"}, 64'(state), 64'd0);
    chk({tag, ".done"}, 64'(done), 64'd0);
    chk({tag, ".pass"}, 64'(pass), 64'd0);
    chk({tag, ".hit_idx"}, 64'(hit_idx), 64'd0);
    chk({tag, ".cycle_cnt"}, 64'(cycle_cnt), 64'd0);
    chk({tag, ".write_cnt"}, 64'(write_cnt), 64'd0);
    chk({tag, ".last_addr"}, last_addr, 64'd0);
    chk({tag, ".last_data"}, last_data, 64'd0);
  endtask

  initial begin
    idle_inputs();
    for (int i = 0; i < NC; i++) begin
      m_en[i] = 0; m_a[i] = 0; m_d[i] = 0; m_m[i] = 0;
    end
    reset = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1;
    // writes in IDLE are ignored
    @(negedge clk); memwrite = 1; dataadr = 64'd100; writedata = 64'd7;
    @(negedge clk); idle_inputs();
    chk("idle.write_cnt", 64'(write_cnt), 64'd0);

    // single entry, hit after 20 quiet cycles
    cfg_write(0, 1, 64'd100, 64'd7, '1);
    clear_stim();
    s_mw[21] = 1; s_a[21] = 64'd100; s_d[21] = 64'd7;
    run("basic");

    // two entries hit, lowest wins
    clear_all_entries();
    cfg_write(1, 1, 64'd508, 64'd7, '1);
    cfg_write(3, 1, 64'd508, 64'd7, '1);
    clear_stim(); fill_random();
    begin
      int k = $urandom_range(5, 200);
      s_mw[k] = 2; s_a[k] = 64'd508; s_d[k] = 64'd7;
    end
    run("prio");

    // nothing enabled
    clear_all_entries();
    clear_stim(); fill_random();
    run("timeout");

    // hit on the timeout cycle wins
    cfg_write(2, 1, 64'd320, 64'd4950, '1);
    clear_stim(); fill_random();
    s_mw[TO] = 3; s_a[TO] = 64'd320; s_d[TO] = 64'd4950;
    run("edge");

    // cfg update in the same cycle as a write uses old contents
    clear_all_entries();
    cfg_write(0, 1, 64'd60, 64'd5, '1);
    clear_stim();
    s_mw[4] = 1; s_a[4] = 64'd60; s_d[4] = 64'd9;
    s_cw[4] = 1; s_ca[4] = 64'd60; s_cd[4] = 64'd9;
    s_mw[6] = 1; s_a[6] = 64'd60; s_d[6] = 64'd9;
    run("cfgold");

    // async reset during DRAIN
    cfg_write(0, 1, 64'd100, 64'd7, '1);
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    repeat (4) @(negedge clk);
    memwrite = 1; dataadr = 64'd100; writedata = 64'd7;
    @(negedge clk); idle_inputs();
    @(negedge clk);
    chk("rst.in_drain", 64'(state), 64'd2);
    #2 reset = 0;
    #1 chk_zero("rst.async");
    for (int i = 0; i < NC; i++) begin
      m_en[i] = 0; m_a[i] = 0; m_d[i] = 0; m_m[i] = 0;
    end
    @(negedge clk); reset = 1;

    // start mid-RUN clears counters, keeps entries
    cfg_write(0, 1, 64'd200, 64'd33, '1);
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    repeat (50) @(negedge clk);
    chk("mid.cnt_before", 64'(cycle_cnt), 64'd50);
    start = 1;
    @(negedge clk); start = 0;
    chk("mid.cnt_cleared", 64'(cycle_cnt), 64'd0);
    chk("mid.state", 64'(state), 64'd1);
    clear_stim(); fill_random();
    s_mw[37] = 1; s_a[37] = 64'd200; s_d[37] = 64'd33;
    run("restart");

    // masked compare (hit only when masking is built)
    clear_all_entries();
    cfg_write(0, 1, 64'd80, 64'd1, 64'hFF);
    clear_stim();
    s_mw[3] = 1; s_a[3] = 64'd80; s_d[3] = 64'h101;
    run("mask");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
